// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EX stage; holds the pipeline via stall until done.
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier (divide stays iterative).
module ex_muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // acc holds the 2*XLEN product for multiplies, {remainder, quotient} for divides
    function automatic logic [XLEN-1:0] select_result(input logic [2:0] f3, input logic neg,
                                                      input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   word;
        prod = neg ? (~acc + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc;
        word = {XLEN{1'b0}};
        case (f3)
            3'b000:                word = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: word = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:        word = neg ? neg_word(acc[XLEN-1:0]) : acc[XLEN-1:0];
            3'b110, 3'b111:        word = neg ? neg_word(acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
            default:               word = {XLEN{1'b0}};
        endcase
        return word;
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   b_mag_q, b_mag_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              done_q, done_d;

    logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s, is_rem_s, neg_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic              div_zero_s, div_ovf_s;
    logic [XLEN-1:0]   special_s;
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_next_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN+1:0]   div_diff_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] div_next_s;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;
`endif

    // Operand decode: signedness per op, magnitudes, result sign and divide special cases
    always_comb begin
        a_signed_s = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed_s = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg_s    = a_signed_s & op_a[XLEN-1];
        b_neg_s    = b_signed_s & op_b[XLEN-1];
        a_mag_s    = a_neg_s ? neg_word(op_a) : op_a;
        b_mag_s    = b_neg_s ? neg_word(op_b) : op_b;
        is_rem_s   = funct3[2] & funct3[1];
        neg_s      = is_rem_s ? a_neg_s : (a_neg_s ^ b_neg_s);
        div_zero_s = (op_b == {XLEN{1'b0}});
        div_ovf_s  = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == {XLEN{1'b1}});
        if (div_zero_s) begin
            special_s = is_rem_s ? op_a : {XLEN{1'b1}};
        end else begin
            special_s = is_rem_s ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration of shift-add multiply (LSB first) and restoring divide (MSB first)
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : {(XLEN+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_q[XLEN-1:1]};
        div_shift_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, b_mag_q};
        div_ge_s    = ~div_diff_s[XLEN+1];
        div_next_s  = {(div_ge_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0]),
                       acc_q[XLEN-2:0], div_ge_s};
    end

`ifdef MULDIV_FAST_MUL_EN
    // Full-width product of the magnitudes for the single-cycle multiply path
    always_comb begin
        fast_prod_s = {{XLEN{1'b0}}, a_mag_s} * {{XLEN{1'b0}}, b_mag_s};
    end
`endif

    // Pipeline hold: asserted while an op is accepted or iterating, released in DONE
    always_comb begin
        stall = ((state_q == S_IDLE) & start & ~flush) | (state_q == S_MUL) | (state_q == S_DIV);
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        done_d   = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        f3_d    = funct3;
                        rd_d    = rd_in;
                        neg_d   = neg_s;
                        b_mag_d = b_mag_s;
                        acc_d   = {{XLEN{1'b0}}, a_mag_s};
                        cnt_d   = {CW{1'b0}};
                        if (funct3[2]) begin
                            if (div_zero_s || div_ovf_s) begin
                                result_d = special_s;
                                rd_out_d = rd_in;
                                done_d   = 1'b1;
                                state_d  = S_DONE;
                            end else begin
                                state_d = S_DIV;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            result_d = select_result(funct3, neg_s, fast_prod_s);
                            rd_out_d = rd_in;
                            done_d   = 1'b1;
                            state_d  = S_DONE;
`else
                            state_d = S_MUL;
`endif
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    acc_d = mul_next_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        result_d = select_result(f3_q, neg_q, mul_next_s);
                        rd_out_d = rd_q;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_MUL;
                    end
                end
                S_DIV: begin
                    acc_d = div_next_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        result_d = select_result(f3_q, neg_q, div_next_s);
                        rd_out_d = rd_q;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            f3_q     <= 3'b000;
            rd_q     <= 5'd0;
            neg_q    <= 1'b0;
            b_mag_q  <= {XLEN{1'b0}};
            acc_q    <= {(2*XLEN){1'b0}};
            result_q <= {XLEN{1'b0}};
            rd_out_q <= 5'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed self-checking bench for ex_muldiv_sequencer: all eight ops, divide special cases,
// flush, mid-op reset and back-to-back issue. Honors MULDIV_FAST_MUL_EN for multiply latency.
module tb_ex_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks;
    int n_pass;
    int mul_cyc;

    ex_muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op at the next cycle; operands are garbled after cycle 0 to prove they are latched.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int exp_cyc, input bit keep);
        int   cyc;
        bit   seen;
        bit   stall_ok;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        cyc = 0; seen = 1'b0; stall_ok = 1'b1;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!stall) stall_ok = 1'b0;
                @(posedge clk); #1;
                cyc++;
                op_a = ~a;
                op_b = b ^ 32'h5555_0001;
            end
        end
        chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_cycle"}, cyc, exp_cyc);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        chk({tag, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
        if (!keep) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        bit any_done;
        n_checks = 0;
        n_pass   = 0;
`ifdef MULDIV_FAST_MUL_EN
        mul_cyc = 1;
`else
        mul_cyc = 33;
`endif
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'b000; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, mul_cyc, 1'b0);
        do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, mul_cyc, 1'b0);
        do_op("mulhu",  3'b011, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, mul_cyc, 1'b0);
        do_op("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'hC000_0000, mul_cyc, 1'b0);
        do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33, 1'b0);
        do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33, 1'b0);
        do_op("divu",   3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        33, 1'b0);
        do_op("remu",   3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         33, 1'b0);
        do_op("div0",   3'b100, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1,  1'b0);
        do_op("rem0",   3'b110, 32'd5,         32'd0,         5'd14, 32'd5,         1,  1'b0);
        do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1,  1'b0);
        do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1,  1'b0);

        // Flush at cycle 10 of a DIV: stall drops next cycle, no done, old result kept
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd20;
        repeat (10) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall_c10", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("flush_stall_after", {31'd0, stall}, 32'd0);
        any_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        chk("flush_no_done", {31'd0, any_done}, 32'd0);
        chk("flush_result_kept", result, 32'd0);
        chk("flush_rd_kept", {27'd0, rd_out}, 32'd16);

        // Flush in the same cycle as start: op never begins
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd21;
        @(negedge clk);
        chk("flush_start_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        any_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || stall) any_done = 1'b1;
        end
        chk("flush_start_idle", {31'd0, any_done}, 32'd0);

        // Back-to-back: MUL 2*3 then DIVU 9/3, start held across the done cycle
        do_op("b2b_mul",  3'b000, 32'd2, 32'd3, 5'd3, 32'd6, mul_cyc, 1'b1);
        do_op("b2b_divu", 3'b101, 32'd9, 32'd3, 5'd4, 32'd3, 33,      1'b0);

        // Reset at cycle 20 of a DIVU clears all outputs
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd22;
        repeat (20) begin
            @(posedge clk); #1;
        end
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_rd", {27'd0, rd_out}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_op("post_rst_mul", 3'b000, 32'd3, 32'd4, 5'd23, 32'd12, mul_cyc, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
